// File: rtl/jamma_input_scanner_pkg.sv
// Shared types and constants for the JAMMA input scanner: scan FSM states,
// idle (released) input levels and JJOY bit positions.
package jamma_pkg;

    typedef enum logic [1:0] {
        P1_SETTLE = 2'd0,
        P1_SAMPLE = 2'd1,
        P2_SETTLE = 2'd2,
        P2_SAMPLE = 2'd3
    } scan_state_e;

    localparam logic [7:0] JOY_IDLE  = 8'hFF;
    localparam logic [1:0] COIN_IDLE = 2'b11;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_START = 7;

endpackage

// File: rtl/jamma_input_scanner_debounce.sv
// Per-bit debounce filter: a bit commits only after DEPTH identical samples
// taken on sample_en cycles; mixed history holds the last committed value.
module jamma_debounce
    import jamma_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [DEPTH-1:0] r_hist;
        logic             r_bit;
        logic [DEPTH-1:0] w_hist_nxt;

        assign w_hist_nxt = {r_hist[DEPTH-2:0], din[b]};

        // Commit is evaluated on the shifted history so dout moves on the same edge as the sample.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hist <= '1;
                r_bit  <= 1'b1;
            end else if (sample_en) begin
                r_hist <= w_hist_nxt;
                if (&w_hist_nxt) begin
                    r_bit <= 1'b1;
                end else if (~|w_hist_nxt) begin
                    r_bit <= 1'b0;
                end
            end
        end

        assign dout[b] = r_bit;
    end

endmodule

// File: rtl/jamma_input_scanner.sv
// JAMMA edge-connector input scanner: sequenced P1/P2 settle/sample schedule,
// input synchronizers and debounce. Two-player mux enabled by `JAMMA_MUX_EN.
module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 16,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       I_CLK,
    input  logic       I_RESET_N,
    input  logic [7:0] I_JJOY,
    input  logic [5:0] I_JOYSTICK,
    input  logic [1:0] I_COIN,
    output logic       O_JSELECT,
    output logic [7:0] O_JOY1,
    output logic [7:0] O_JOY2,
    output logic [1:0] O_COIN,
    output logic       O_SCAN_TICK
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("jamma_input_scanner: SETTLE_CYCLES must be at least 3");
    end
    if (DEBOUNCE_SAMPLES < 2) begin : g_bad_depth
        $error("jamma_input_scanner: DEBOUNCE_SAMPLES must be at least 2");
    end

    logic [7:0]  r_jjoy_s1, r_jjoy_s2;
    logic [5:0]  r_joy_s1,  r_joy_s2;
    logic [1:0]  r_coin_s1, r_coin_s2;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_jjoy_s1 <= JOY_IDLE;
            r_jjoy_s2 <= JOY_IDLE;
            r_joy_s1  <= '1;
            r_joy_s2  <= '1;
            r_coin_s1 <= COIN_IDLE;
            r_coin_s2 <= COIN_IDLE;
        end else begin
            r_jjoy_s1 <= I_JJOY;
            r_jjoy_s2 <= r_jjoy_s1;
            r_joy_s1  <= I_JOYSTICK;
            r_joy_s2  <= r_joy_s1;
            r_coin_s1 <= I_COIN;
            r_coin_s2 <= r_coin_s1;
        end
    end

    scan_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_p1_sample, w_p2_sample;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state <= P1_SETTLE;
            r_cnt   <= CNT_RELOAD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter stops at zero and is only ever reloaded on a sample cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p1_sample = 1'b0;
        w_p2_sample = 1'b0;
        case (r_state)
            P1_SETTLE: begin
                if (r_cnt == '0) w_state_nxt = P1_SAMPLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            P1_SAMPLE: begin
                w_p1_sample = 1'b1;
                w_cnt_nxt   = CNT_RELOAD;
                w_state_nxt = P2_SETTLE;
            end
            P2_SETTLE: begin
                if (r_cnt == '0) w_state_nxt = P2_SAMPLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            P2_SAMPLE: begin
                w_p2_sample = 1'b1;
                w_cnt_nxt   = CNT_RELOAD;
                w_state_nxt = P1_SETTLE;
            end
            default: begin
                w_state_nxt = P1_SETTLE;
                w_cnt_nxt   = CNT_RELOAD;
            end
        endcase
    end

    assign O_SCAN_TICK = w_p2_sample;

    logic [7:0] w_p1_vec;
    assign w_p1_vec = {2'b11, r_joy_s2} & r_jjoy_s2;

    jamma_debounce #(.WIDTH(8), .DEPTH(DEBOUNCE_SAMPLES)) u_p1_filter (
        .clk       (I_CLK),
        .rst_n     (I_RESET_N),
        .sample_en (w_p1_sample),
        .din       (w_p1_vec),
        .dout      (O_JOY1)
    );

    jamma_debounce #(.WIDTH(2), .DEPTH(DEBOUNCE_SAMPLES)) u_coin_filter (
        .clk       (I_CLK),
        .rst_n     (I_RESET_N),
        .sample_en (w_p2_sample),
        .din       (r_coin_s2),
        .dout      (O_COIN)
    );

`ifdef JAMMA_MUX_EN
    logic r_jselect;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_jselect <= 1'b0;
        end else begin
            r_jselect <= (w_state_nxt == P2_SETTLE) || (w_state_nxt == P2_SAMPLE);
        end
    end

    assign O_JSELECT = r_jselect;

    jamma_debounce #(.WIDTH(8), .DEPTH(DEBOUNCE_SAMPLES)) u_p2_filter (
        .clk       (I_CLK),
        .rst_n     (I_RESET_N),
        .sample_en (w_p2_sample),
        .din       (r_jjoy_s2),
        .dout      (O_JOY2)
    );
`else
    assign O_JSELECT = 1'b0;
    assign O_JOY2    = JOY_IDLE;
`endif

endmodule
